// File: rtl/cache_arbiter_pkg.sv
// ============================================================================
// Module      : cache_arbiter_pkg
// Description : Shared LC-3b types and the arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter_reg.sv
// ============================================================================
// Module      : cache_arbiter_reg
// Description : Loadable register with synchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = i_load ? i_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
// Module      : cache_arbiter
// Description : Round-robin arbiter sharing one L2 port between I- and D-cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic [CNT_W-1:0]  i_grant_count,
    output logic [CNT_W-1:0]  d_grant_count
);

    localparam int LATCH_W = 1 + ADDR_W + LINE_W;

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;

    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_serving;
    logic [LATCH_W-1:0] w_latch_in;
    logic [LATCH_W-1:0] w_latch_out;
    logic              w_lat_rw;

    assign w_d_req = d_pmem_read | d_pmem_write;

    // Conflicts go to whichever side was not granted last.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (state_q == IDLE) begin
            w_grant_d = w_d_req && (!i_pmem_read || (last_grant_q == GRANT_I));
            w_grant_i = i_pmem_read && !w_grant_d;
        end
    end

    always_comb begin
        w_latch_in = {1'b0, i_pmem_address, {LINE_W{1'b0}}};
        if (w_grant_d) begin
            w_latch_in = {d_pmem_write, d_pmem_address, d_pmem_wdata};
        end
    end

    cache_arbiter_reg #(
        .WIDTH (LATCH_W)
    ) u_latch (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_grant_i | w_grant_d),
        .i_data (w_latch_in),
        .o_data (w_latch_out)
    );

    assign w_lat_rw   = w_latch_out[LATCH_W-1];
    assign l2_address = w_latch_out[LINE_W +: ADDR_W];
    assign l2_wdata   = w_latch_out[LINE_W-1:0];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        i_cnt_d      = i_cnt_q;
        d_cnt_d      = d_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                    d_cnt_d      = (d_cnt_q == {CNT_W{1'b1}}) ? d_cnt_q : d_cnt_q + CNT_W'(1);
                end else if (w_grant_i) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                    i_cnt_d      = (i_cnt_q == {CNT_W{1'b1}}) ? i_cnt_q : i_cnt_q + CNT_W'(1);
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            i_cnt_q      <= '0;
            d_cnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            i_cnt_q      <= i_cnt_d;
            d_cnt_q      <= d_cnt_d;
        end
    end

    // Outputs are gated by rst_n so an in-flight request vanishes during reset.
    assign w_serving     = rst_n && (state_q != IDLE);
    assign l2_read       = w_serving && !w_lat_rw;
    assign l2_write      = w_serving &&  w_lat_rw;
    assign i_pmem_resp   = rst_n && (state_q == SERVE_I) && l2_resp;
    assign d_pmem_resp   = rst_n && (state_q == SERVE_D) && l2_resp;
    assign i_pmem_rdata  = l2_rdata;
    assign d_pmem_rdata  = l2_rdata;
    assign i_grant_count = i_cnt_q;
    assign d_grant_count = d_cnt_q;

    a_no_dual_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        !(d_pmem_read && d_pmem_write));

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Scoreboard bench for cache_arbiter with an L2 responder model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata;
    logic         l2_resp;
    logic [15:0]  i_grant_count;
    logic [15:0]  d_grant_count;

    // Narrow-counter instance used to reach saturation in a few grants.
    logic         s_i_read = 1'b0;
    logic [15:0]  s_zero_addr = 16'h0;
    logic [127:0] s_zero_line = '0;
    logic         s_d_read;
    logic         s_d_write = 1'b0;
    logic [127:0] s_i_rdata, s_d_rdata, s_l2_wdata;
    logic         s_i_resp, s_d_resp, s_l2_read, s_l2_write, s_l2_resp;
    logic [15:0]  s_l2_address;
    logic [1:0]   s_i_cnt, s_d_cnt;

    assign s_l2_resp = s_l2_read;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
    );

    cache_arbiter #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(s_i_read), .i_pmem_address(s_zero_addr),
        .i_pmem_rdata(s_i_rdata), .i_pmem_resp(s_i_resp),
        .d_pmem_read(s_d_read), .d_pmem_write(s_d_write),
        .d_pmem_address(s_zero_addr), .d_pmem_wdata(s_zero_line),
        .d_pmem_rdata(s_d_rdata), .d_pmem_resp(s_d_resp),
        .l2_read(s_l2_read), .l2_write(s_l2_write), .l2_address(s_l2_address),
        .l2_wdata(s_l2_wdata), .l2_rdata(s_zero_line), .l2_resp(s_l2_resp),
        .i_grant_count(s_i_cnt), .d_grant_count(s_d_cnt)
    );

    typedef struct packed {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } l2req_t;

    l2req_t       exp_l2_q[$];
    logic [127:0] exp_i_q[$];
    logic [127:0] exp_d_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int l2_dly   = 2;
    int cyc      = 0;
    int last_det_cyc = 0;
    int d_resp_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred that was not expected", name);
    endtask

    function automatic logic [127:0] l2_data(input logic [15:0] a);
        if (a == 16'h0040) return {16{8'hA5}};
        return {8{a}};
    endfunction

    // L2 model: checks each new request against the expected order, answers after l2_dly cycles.
    initial begin
        l2_resp  = 1'b0;
        l2_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && (l2_read || l2_write)) begin
                l2req_t e;
                logic   aborted;
                e = '0;
                last_det_cyc = cyc;
                if (exp_l2_q.size() == 0) begin
                    fail_now("l2_unexpected_request");
                end else begin
                    e = exp_l2_q.pop_front();
                    check("l2_write_flag", {127'd0, l2_write}, {127'd0, e.wr});
                    check("l2_read_flag", {127'd0, l2_read}, {127'd0, !e.wr});
                    check("l2_address", {112'd0, l2_address}, {112'd0, e.addr});
                    if (e.wr) check("l2_wdata", l2_wdata, e.wdata);
                end
                aborted = 1'b0;
                for (int c = 0; c < l2_dly; c++) begin
                    @(posedge clk); #1;
                    if (!rst_n) aborted = 1'b1;
                end
                if (!aborted) begin
                    check("l2_address_held", {112'd0, l2_address}, {112'd0, e.addr});
                    l2_rdata = l2_data(l2_address);
                    l2_resp  = 1'b1;
                    @(posedge clk); #1;
                    l2_resp  = 1'b0;
                    l2_rdata = '0;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (i_pmem_resp && d_pmem_resp) fail_now("both_resp_same_cycle");
            if (i_pmem_resp) begin
                if (exp_i_q.size() == 0) fail_now("i_resp_unexpected");
                else check("i_pmem_rdata", i_pmem_rdata, exp_i_q.pop_front());
            end
            if (d_pmem_resp) begin
                d_resp_cyc = cyc;
                if (exp_d_q.size() == 0) fail_now("d_resp_unexpected");
                else check("d_pmem_rdata", d_pmem_rdata, exp_d_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic req_i(input logic [15:0] a);
        logic got;
        i_pmem_address = a;
        i_pmem_read    = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (i_pmem_resp) begin got = 1'b1; break; end
        end
        if (!got) fail_now("i_resp_timeout");
        @(posedge clk); #1;
        i_pmem_read = 1'b0;
    endtask

    task automatic req_d(input logic [15:0] a, input logic wr, input logic [127:0] wd,
                         input logic move_addr);
        logic got;
        d_pmem_address = a;
        d_pmem_wdata   = wd;
        d_pmem_write   = wr;
        d_pmem_read    = !wr;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (move_addr && c == 1) d_pmem_address = 16'hBEEF;
            if (d_pmem_resp) begin got = 1'b1; break; end
        end
        if (!got) fail_now("d_resp_timeout");
        @(posedge clk); #1;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
    endtask

    task automatic counts(input string name, input logic [15:0] ei, input logic [15:0] ed);
        check({name, "_i_cnt"}, {112'd0, i_grant_count}, {112'd0, ei});
        check({name, "_d_cnt"}, {112'd0, d_grant_count}, {112'd0, ed});
    endtask

    initial begin
        logic got;
        rst_n = 1'b0;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        s_d_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_l2_read", {127'd0, l2_read}, 128'd0);
        check("rst_l2_write", {127'd0, l2_write}, 128'd0);
        check("rst_i_resp", {127'd0, i_pmem_resp}, 128'd0);
        check("rst_d_resp", {127'd0, d_pmem_resp}, 128'd0);
        check("rst_l2_address", {112'd0, l2_address}, 128'd0);
        counts("rst", 16'd0, 16'd0);
        check("rst_sat_cnt", {126'd0, s_d_cnt}, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // I-only read, L2 answers after 5 cycles.
        l2_dly = 5;
        exp_l2_q.push_back('{1'b0, 16'h0040, 128'd0});
        exp_i_q.push_back({16{8'hA5}});
        check("t1_l2_read_before", {127'd0, l2_read}, 128'd0);
        fork
            req_i(16'h0040);
            begin @(posedge clk); #1; check("t1_l2_read_n1", {127'd0, l2_read}, 128'd1); end
        join
        counts("t1", 16'd1, 16'd0);

        // First conflict: last grant is I, so D goes first.
        l2_dly = 2;
        exp_l2_q.push_back('{1'b0, 16'h0200, 128'd0});
        exp_l2_q.push_back('{1'b0, 16'h0300, 128'd0});
        exp_d_q.push_back({8{16'h0200}});
        exp_i_q.push_back({8{16'h0300}});
        fork
            req_i(16'h0300);
            req_d(16'h0200, 1'b0, '0, 1'b0);
        join
        counts("t2", 16'd2, 16'd1);

        // D write-back with address moved mid-service; I arrives during SERVE_D.
        l2_dly = 4;
        exp_l2_q.push_back('{1'b1, 16'h1230, {8{16'h1234}}});
        exp_l2_q.push_back('{1'b0, 16'h0400, 128'd0});
        exp_d_q.push_back({8{16'h1230}});
        exp_i_q.push_back({8{16'h0400}});
        fork
            req_d(16'h1230, 1'b1, {8{16'h1234}}, 1'b1);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                req_i(16'h0400);
            end
        join
        check("t3_i_grant_cycle", 128'(last_det_cyc), 128'(d_resp_cyc + 2));
        counts("t3", 16'd3, 16'd2);

        // D alone, so last grant becomes D; the next conflict then favours I.
        l2_dly = 1;
        exp_l2_q.push_back('{1'b0, 16'h0500, 128'd0});
        exp_d_q.push_back({8{16'h0500}});
        req_d(16'h0500, 1'b0, '0, 1'b0);

        l2_dly = 2;
        exp_l2_q.push_back('{1'b0, 16'h0600, 128'd0});
        exp_l2_q.push_back('{1'b0, 16'h0700, 128'd0});
        exp_i_q.push_back({8{16'h0600}});
        exp_d_q.push_back({8{16'h0700}});
        fork
            req_i(16'h0600);
            req_d(16'h0700, 1'b0, '0, 1'b0);
        join
        counts("t5", 16'd4, 16'd4);

        // Reset while SERVE_I is waiting on a slow L2.
        l2_dly = 20;
        exp_l2_q.push_back('{1'b0, 16'h0800, 128'd0});
        i_pmem_address = 16'h0800;
        i_pmem_read    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_serving", {127'd0, l2_read}, 128'd1);
        #1;
        rst_n       = 1'b0;
        i_pmem_read = 1'b0;
        #1;
        check("t6_rst_l2_read", {127'd0, l2_read}, 128'd0);
        check("t6_rst_i_resp", {127'd0, i_pmem_resp}, 128'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("t6_post_l2_read", {127'd0, l2_read}, 128'd0);
        counts("t6", 16'd0, 16'd0);
        repeat (25) @(posedge clk);
        #2;

        // Saturation on the 2-bit instance: 1, 2, 3, then holds at 3.
        for (int k = 0; k < 4; k++) begin
            s_d_read = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (s_d_resp) begin got = 1'b1; break; end
            end
            if (!got) fail_now("sat_resp_timeout");
            @(posedge clk); #1;
            s_d_read = 1'b0;
            check("sat_d_cnt", {126'd0, s_d_cnt}, (k < 3) ? 128'(k + 1) : 128'd3);
            @(posedge clk); #1;
        end

        check("exp_l2_drained", 128'(exp_l2_q.size()), 128'd0);
        check("exp_i_drained", 128'(exp_i_q.size()), 128'd0);
        check("exp_d_drained", 128'(exp_d_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
